// File: rtl/fp_divsqrt_issue_ctrl.sv
// fp_divsqrt_issue_ctrl: request FIFO and single-issue controller in front of the iterative FP div/sqrt unit
module fp_divsqrt_issue_ctrl #(
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [FP_WIDTH-1:0]        req_opa_i,
    input  logic [FP_WIDTH-1:0]        req_opb_i,
    input  logic                       req_sqrt_i,
    input  logic [TAG_WIDTH-1:0]       req_tag_i,
    input  logic [RND_WIDTH-1:0]       req_rnd_i,
    output logic                       En_o,
    output logic [FP_WIDTH-1:0]        OpA_o,
    output logic [FP_WIDTH-1:0]        OpB_o,
    output logic                       sqrt_sel_o,
    output logic [RND_WIDTH-1:0]       Rnd_o,
    input  logic                       unit_ready_i,
    input  logic                       unit_valid_i,
    input  logic [FP_WIDTH-1:0]        unit_res_i,
    input  logic [STAT_WIDTH-1:0]      unit_status_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [FP_WIDTH-1:0]        resp_res_o,
    output logic [STAT_WIDTH-1:0]      resp_status_o,
    output logic [TAG_WIDTH-1:0]       resp_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 2*FP_WIDTH + 1 + RND_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        head;
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 push, issue, done;

    assign req_ready_o  = count_q < CW'(DEPTH);
    assign push         = req_valid_i & req_ready_o;
    assign issue        = (count_q != '0) & unit_ready_i & (state_q == IDLE | (state_q == HOLD & resp_ready_i));
    assign done         = (state_q == BUSY) & unit_valid_i;
    // Head is forced to zero when empty so stale entries never reach the unit
    assign head         = (count_q != '0) ? mem[rd_ptr] : '0;
    assign {OpA_o, OpB_o, sqrt_sel_o, Rnd_o} = head[EW-1:TAG_WIDTH];
    assign En_o         = issue;
    assign resp_valid_o = state_q == HOLD;
    assign count_o      = count_q;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {req_opa_i, req_opb_i, req_sqrt_i, req_rnd_i, req_tag_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count_q       <= '0;
            tag_q         <= '0;
            resp_res_o    <= '0;
            resp_status_o <= '0;
            resp_tag_o    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CW'(push) - CW'(issue);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
                tag_q  <= head[TAG_WIDTH-1:0];
            end
            if (done) begin
                resp_res_o    <= unit_res_i;
                resp_status_o <= unit_status_i;
                resp_tag_o    <= tag_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (issue) state_d = BUSY;
        else if (done) state_d = HOLD;
        else if (state_q == HOLD & resp_ready_i) state_d = IDLE;
    end
endmodule

// File: tb/tb_fp_divsqrt_issue_ctrl.sv
// tb_fp_divsqrt_issue_ctrl: directed and randomized checks against a queue-based model of the issue controller
module tb_fp_divsqrt_issue_ctrl;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [2:0]  r;
        logic [4:0]  t;
    } req_t;

    logic        clk_i = 0, rst_ni = 0;
    logic        req_valid_i = 0, req_ready_o, req_sqrt_i = 0;
    logic [31:0] req_opa_i = 0, req_opb_i = 0;
    logic [4:0]  req_tag_i = 0;
    logic [2:0]  req_rnd_i = 0;
    logic        En_o, sqrt_sel_o;
    logic [31:0] OpA_o, OpB_o;
    logic [2:0]  Rnd_o;
    logic        unit_ready_i = 0, unit_valid_i = 0;
    logic [31:0] unit_res_i = 0;
    logic [4:0]  unit_status_i = 0;
    logic        resp_valid_o, resp_ready_i = 0;
    logic [31:0] resp_res_o;
    logic [4:0]  resp_status_o, resp_tag_o;
    logic [2:0]  count_o;

    int checks = 0, failures = 0;
    int lat = 0, lat_set = 0;
    logic spur = 0;
    req_t q[$];
    logic [4:0] inf_q[$];
    logic [41:0] rsp_q[$];

    fp_divsqrt_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_sqrt_i(req_sqrt_i),
        .req_tag_i(req_tag_i), .req_rnd_i(req_rnd_i),
        .En_o(En_o), .OpA_o(OpA_o), .OpB_o(OpB_o), .sqrt_sel_o(sqrt_sel_o), .Rnd_o(Rnd_o),
        .unit_ready_i(unit_ready_i), .unit_valid_i(unit_valid_i),
        .unit_res_i(unit_res_i), .unit_status_i(unit_status_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_res_o(resp_res_o), .resp_status_o(resp_status_o), .resp_tag_o(resp_tag_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(logic v, logic [31:0] a, logic [31:0] b, logic s, logic [4:0] t);
        req_valid_i = v; req_opa_i = a; req_opb_i = b; req_sqrt_i = s; req_tag_i = t; req_rnd_i = t[2:0];
    endtask

    // One clock: inputs already set at the negedge, outputs checked 1ns later, model advanced for the posedge
    task automatic cycle();
        logic exp_issue, push, done, acc;
        req_t h;
        unit_res_i    = $urandom;
        unit_status_i = 5'($urandom);
        unit_valid_i  = (inf_q.size() != 0) ? (lat == 0) : spur;
        #1;
        exp_issue = q.size() != 0 && unit_ready_i && inf_q.size() == 0 && (rsp_q.size() == 0 || resp_ready_i);
        h = (q.size() != 0) ? q[0] : '0;
        chk("req_ready", req_ready_o, q.size() < DEPTH);
        chk("count", count_o, q.size());
        chk("en", En_o, exp_issue);
        chk("head", {OpA_o, OpB_o, sqrt_sel_o, Rnd_o}, {h.a, h.b, h.s, h.r});
        chk("resp_valid", resp_valid_o, rsp_q.size() != 0);
        if (rsp_q.size() != 0) chk("resp", {resp_res_o, resp_status_o, resp_tag_o}, rsp_q[0]);
        push = req_valid_i && q.size() < DEPTH;
        done = inf_q.size() != 0 && unit_valid_i;
        acc  = rsp_q.size() != 0 && resp_ready_i;
        if (acc) void'(rsp_q.pop_front());
        if (done) begin
            rsp_q.push_back({unit_res_i, unit_status_i, inf_q[0]});
            void'(inf_q.pop_front());
        end else if (inf_q.size() != 0) lat--;
        if (exp_issue) begin
            inf_q.push_back(q[0].t);
            void'(q.pop_front());
            lat = lat_set;
        end
        if (push) q.push_back({req_opa_i, req_opb_i, req_sqrt_i, req_rnd_i, req_tag_i});
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 0; req_valid_i = 0; unit_ready_i = 0; resp_ready_i = 0; unit_valid_i = 0; spur = 0;
        q.delete(); inf_q.delete(); rsp_q.delete();
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_zero", {count_o, En_o, resp_valid_o, resp_res_o, resp_status_o, resp_tag_o,
                         OpA_o, OpB_o, sqrt_sel_o, Rnd_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic single_div();
        unit_ready_i = 1; resp_ready_i = 1; lat_set = 11;
        set_req(1, 32'h40400000, 32'h3F800000, 0, 3);
        cycle();
        req_valid_i = 0;
        repeat (16) cycle();
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();
        single_div();
        // fill the FIFO with the unit stalled, fifth request waits for the first issue
        unit_ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(1, $urandom, $urandom, 1'($urandom), 5'(i));
            cycle();
        end
        unit_ready_i = 1; lat_set = 1;
        cycle();
        cycle();
        req_valid_i = 0;
        repeat (30) cycle();
        // response backpressure with two requests queued behind the one in flight
        resp_ready_i = 0; lat_set = 2;
        for (int i = 8; i < 11; i++) begin
            set_req(1, $urandom, $urandom, 0, 5'(i));
            cycle();
        end
        req_valid_i = 0;
        repeat (25) cycle();
        resp_ready_i = 1;
        repeat (20) cycle();
        spur = 1;
        cycle();
        spur = 0;
        cycle();
        set_req(1, 32'h40800000, 32'h0, 1, 7);
        cycle();
        req_valid_i = 0;
        repeat (10) cycle();
        // reset while busy with three queued
        unit_ready_i = 0;
        for (int i = 20; i < 24; i++) begin
            set_req(1, $urandom, $urandom, 0, 5'(i));
            cycle();
        end
        req_valid_i = 0; unit_ready_i = 1; lat_set = 30;
        repeat (4) cycle();
        do_reset();
        single_div();
        repeat (3000) begin
            set_req(1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom));
            unit_ready_i = ($urandom % 4) != 0;
            resp_ready_i = ($urandom % 3) != 0;
            lat_set      = $urandom_range(0, 6);
            spur         = ($urandom % 8) == 0;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
